// File: rtl/fuzz_pkg.sv
// Shared definitions for the fuzz Wishbone master.
//   state_e  : controller states (idle, bus cycle in flight, completion)
//   ERR_DATA : read data returned when a cycle ends by error or timeout
package fuzz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/fuzz_wb_master.sv
// Single-transaction Wishbone classic master driven by a simple level request.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   ext_master_req/we/addr_*/wdata: request side, sampled only in IDLE
//   ext_master_rdata              : last read data, held between reads
//   ext_master_read/write_done    : one-cycle completion pulses
//   ext_master_err                : valid with a done pulse, error or timeout
//   wb_*                          : Wishbone master signals, all registered
module fuzz_wb_master
    import fuzz_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ext_master_req,
    input  logic                    ext_master_we,
    input  logic [ADDR_WIDTH-1:0]   ext_master_addr_read,
    input  logic [ADDR_WIDTH-1:0]   ext_master_addr_write,
    input  logic [DATA_WIDTH-1:0]   ext_master_wdata,
    output logic [DATA_WIDTH-1:0]   ext_master_rdata,
    output logic                    ext_master_read_done,
    output logic                    ext_master_write_done,
    output logic                    ext_master_err,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    read_done_q, read_done_d;
    logic                    write_done_q, write_done_d;
    logic                    err_q, err_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic timeout;
    logic fail;
    logic term;

    assign timeout = (cnt_q == CNT_LAST);
    // Error (including timeout) takes priority over a simultaneous ack.
    assign fail    = wb_err_i | timeout;
    assign term    = wb_ack_i | fail;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ext_master_req) state_d = ST_BUS;
            ST_BUS:  if (term)           state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Output logic, computing the next value of every registered output
    always_comb begin
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        rdata_d      = rdata_q;
        read_done_d  = 1'b0;
        write_done_d = 1'b0;
        err_d        = 1'b0;
        cnt_d        = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ext_master_req) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    sel_d = '1;
                    we_d  = ext_master_we;
                    adr_d = ext_master_we ? ext_master_addr_write : ext_master_addr_read;
                    dat_d = ext_master_wdata;
                    cnt_d = '0;
                end
            end
            ST_BUS: begin
                if (term) begin
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    sel_d        = '0;
                    read_done_d  = ~we_q;
                    write_done_d = we_q;
                    err_d        = fail;
                    if (!we_q) begin
                        rdata_d = fail ? DATA_WIDTH'(ERR_DATA) : wb_dat_i;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rdata_q      <= '0;
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            rdata_q      <= rdata_d;
            read_done_q  <= read_done_d;
            write_done_q <= write_done_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign wb_cyc_o              = cyc_q;
    assign wb_stb_o              = stb_q;
    assign wb_we_o               = we_q;
    assign wb_adr_o              = adr_q;
    assign wb_dat_o              = dat_q;
    assign wb_sel_o              = sel_q;
    assign ext_master_rdata      = rdata_q;
    assign ext_master_read_done  = read_done_q;
    assign ext_master_write_done = write_done_q;
    assign ext_master_err        = err_q;

endmodule

// File: tb/tb_fuzz_wb_master.sv
// Directed self-checking bench for fuzz_wb_master (TIMEOUT_CYCLES = 8).
module tb_fuzz_wb_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [AW-1:0] addr_read;
    logic [AW-1:0] addr_write;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          read_done;
    logic          write_done;
    logic          err;
    logic          cyc;
    logic          stb;
    logic          wb_we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_o;
    logic [DW/8-1:0] sel;
    logic [DW-1:0] dat_i;
    logic          ack;
    logic          err_i;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int cycle    = 0;

    fuzz_wb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ext_master_req       (req),
        .ext_master_we        (we),
        .ext_master_addr_read (addr_read),
        .ext_master_addr_write(addr_write),
        .ext_master_wdata     (wdata),
        .ext_master_rdata     (rdata),
        .ext_master_read_done (read_done),
        .ext_master_write_done(write_done),
        .ext_master_err       (err),
        .wb_cyc_o             (cyc),
        .wb_stb_o             (stb),
        .wb_we_o              (wb_we),
        .wb_adr_o             (adr),
        .wb_dat_o             (dat_o),
        .wb_sel_o             (sel),
        .wb_dat_i             (dat_i),
        .wb_ack_i             (ack),
        .wb_err_i             (err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (read_done || write_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr_read = '0; addr_write = '0;
        wdata = '0; dat_i = '0; ack = 1'b0; err_i = 1'b0;
        #12;
        checks++; if ({cyc, stb, wb_we, sel} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0", {cyc, stb, wb_we, sel});
        end
        checks++; if ({adr, dat_o, rdata} !== 96'h0) begin
            failures++; $display("FAIL reset_data adr=%h dat=%h rdata=%h want 0", adr, dat_o, rdata);
        end
        checks++; if ({read_done, write_done, err} !== 3'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=000", {read_done, write_done, err});
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int d0;
        d0 = done_cnt;
        req = 1'b1; we = 1'b0; addr_read = 32'h4000_0010; addr_write = 32'h7777_0000;
        tick();
        req = 1'b0; addr_read = 32'h0BAD_0000;
        checks++; if ({cyc, stb, wb_we, sel, adr} !== {3'b110, 4'hF, 32'h4000_0010}) begin
            failures++; $display("FAIL read_start cyc/stb/we/sel=%b adr=%h want 110_1111 40000010",
                                 {cyc, stb, wb_we, sel}, adr);
        end
        tick();
        checks++; if (cyc !== 1'b1 || adr !== 32'h4000_0010) begin
            failures++; $display("FAIL read_hold cyc=%b adr=%h want 1 40000010", cyc, adr);
        end
        ack = 1'b1; dat_i = 32'h1234_5678;
        tick();
        ack = 1'b0; dat_i = '0;
        checks++; if ({cyc, stb, read_done, write_done, err} !== 5'b00100) begin
            failures++; $display("FAIL read_done_flags got=%b want=00100", {cyc, stb, read_done, write_done, err});
        end
        checks++; if (rdata !== 32'h1234_5678) begin
            failures++; $display("FAIL read_data got=%h want=12345678", rdata);
        end
        tick();
        checks++; if (read_done !== 1'b0 || done_cnt - d0 !== 1) begin
            failures++; $display("FAIL read_pulse rd=%b pulses=%0d want 0 1", read_done, done_cnt - d0);
        end
    endtask

    task automatic test_write();
        req = 1'b1; we = 1'b1; addr_write = 32'h3000_0000; addr_read = 32'h5555_0000;
        wdata = 32'hA000_0111;
        tick();
        req = 1'b0;
        checks++; if ({cyc, wb_we, adr, dat_o} !== {2'b11, 32'h3000_0000, 32'hA000_0111}) begin
            failures++; $display("FAIL write_start cyc=%b we=%b adr=%h dat=%h want 1 1 30000000 a0000111",
                                 cyc, wb_we, adr, dat_o);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if ({cyc, read_done, write_done, err} !== 4'b0010) begin
            failures++; $display("FAIL write_done_flags got=%b want=0010", {cyc, read_done, write_done, err});
        end
        checks++; if (rdata !== 32'h1234_5678) begin
            failures++; $display("FAIL write_rdata_kept got=%h want=12345678", rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        req = 1'b1; we = 1'b0; addr_read = 32'h6000_0000;
        tick();
        req = 1'b0;
        n = 0;
        while (cyc === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++; if (n !== 8) begin
            failures++; $display("FAIL timeout_len got=%0d want=8", n);
        end
        checks++; if ({read_done, err, write_done} !== 3'b110 || rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL timeout_end rd/err/wr=%b rdata=%h want 110 deadbeef",
                                 {read_done, err, write_done}, rdata);
        end
        tick();
        checks++; if (err !== 1'b0) begin
            failures++; $display("FAIL timeout_err_clear got=%b want=0", err);
        end
    endtask

    task automatic test_back_to_back();
        int last_done;
        int k;
        req = 1'b1; we = 1'b0; addr_read = 32'h0000_1000;
        last_done = -100;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (cyc !== 1'b1 && k < 10) begin
                k++;
                tick();
            end
            checks++; if (cyc !== 1'b1 || adr !== 32'h0000_1000 + 32'(4 * i)) begin
                failures++; $display("FAIL b2b_addr[%0d] cyc=%b adr=%h want 1 %h", i, cyc, adr,
                                     32'h0000_1000 + 32'(4 * i));
            end
            ack = 1'b1; dat_i = 32'hC0DE_0000 + 32'(i);
            tick();
            ack = 1'b0;
            if (i == 3) req = 1'b0;
            addr_read = addr_read + 32'd4;
            checks++; if (read_done !== 1'b1 || rdata !== 32'hC0DE_0000 + 32'(i)) begin
                failures++; $display("FAIL b2b_done[%0d] rd=%b rdata=%h want 1 %h", i, read_done, rdata,
                                     32'hC0DE_0000 + 32'(i));
            end
            checks++; if (cycle - last_done < 3) begin
                failures++; $display("FAIL b2b_spacing[%0d] got=%0d want>=3", i, cycle - last_done);
            end
            last_done = cycle;
            tick();
        end
        tick(); tick();
        checks++; if (cyc !== 1'b0) begin
            failures++; $display("FAIL b2b_idle cyc=%b want=0", cyc);
        end
    endtask

    task automatic test_error();
        req = 1'b1; we = 1'b0; addr_read = 32'h0000_0050;
        tick();
        req = 1'b0;
        ack = 1'b1; err_i = 1'b1; dat_i = 32'h1111_2222;
        tick();
        ack = 1'b0; err_i = 1'b0;
        checks++; if ({cyc, read_done, err} !== 3'b011 || rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL error_end cyc/rd/err=%b rdata=%h want 011 deadbeef",
                                 {cyc, read_done, err}, rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_bus();
        int d0;
        req = 1'b1; we = 1'b0; addr_read = 32'h0000_0abc;
        tick();
        req = 1'b0;
        d0 = done_cnt;
        checks++; if (cyc !== 1'b1) begin
            failures++; $display("FAIL rst_bus_pre cyc=%b want=1", cyc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({cyc, stb, sel} !== 6'b0) begin
            failures++; $display("FAIL rst_bus_drop got=%b want=0", {cyc, stb, sel});
        end
        ack = 1'b1;
        tick(); tick();
        ack = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (done_cnt !== d0 || cyc !== 1'b0) begin
            failures++; $display("FAIL rst_bus_nodone pulses=%0d cyc=%b want %0d 0", done_cnt, cyc, d0);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_back_to_back();
        test_error();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
